fetch_stage: RTL and testbench

Instruction-fetch stage sitting directly upstream of decode, and hence of the branch resolution unit in EX. It owns the architectural PC and issues word requests to a 1-cycle-latency instruction BRAM. Returned instructions are buffered in a 2-entry queue that feeds the IF/ID interface. It consumes the branch unit's BranchTaken/target outputs to redirect the PC and squash wrong-path fetches.

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/fetch_stage_if.sv | 33 +++
 rtl/fetch_buffer.sv | 52 +++++
 rtl/fetch_stage.sv | 80 ++++++++
 tb/tb_fetch_stage.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and IF/ID bundle type for the fetch stage.
// RESET_PC_DEF seeds the default reset vector.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam int          BUF_DEPTH_DEF = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port and IF/ID handshake bundle.
// master = fetch side, slave = memory/decode side.
interface fetch_stage_if;

  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic [31:0] ImemRdata;
  logic        Stall;
  logic        IfIdValid;
  logic [31:0] IfIdPc;
  logic [31:0] IfIdInstr;

  modport master (
    output ImemReq,
    output ImemAddr,
    input  ImemRdata,
    input  Stall,
    output IfIdValid,
    output IfIdPc,
    output IfIdInstr
  );

  modport slave (
    input  ImemReq,
    input  ImemAddr,
    output ImemRdata,
    output Stall,
    input  IfIdValid,
    input  IfIdPc,
    input  IfIdInstr
  );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry {pc, instr} queue between IMEM and decode.
// Flush beats push; entry 0 is always the head.
module fetch_buffer
  import fetch_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  if_id_t     din,
  output if_id_t     head,
  output logic [1:0] count
);

  if_id_t e0;
  if_id_t e1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case (1'b1)
        push && pop: begin
          if (count == 2'd2) begin
            e0 <= e1;
            e1 <= din;
          end else begin
            e0 <= din;
          end
        end
        push && !pop: begin
          if (count == 2'd0) e0 <= din;
          else               e1 <= din;
          count <= count + 2'd1;
        end
        pop && !push: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign head = e0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, IMEM credit logic, redirect and squash.
// IF/ID outputs come only from the queue registers.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus,
  input  logic          BranchTaken,
  input  logic [31:0]   BranchPc,
  output logic          MisalignFault
);

  logic [31:0] pc;
  logic        in_flight;
  logic [31:0] in_flight_pc;
  logic        discard;
  logic        pop;
  logic        push;
  logic        req;
  logic        valid;
  logic [2:0]  occ;
  logic [1:0]  buf_count;
  if_id_t      buf_head;
  if_id_t      buf_din;

  assign valid = (buf_count != 2'd0);
  assign pop   = valid && !bus.Stall;
  assign push  = in_flight && !discard && !BranchTaken;

  // Occupancy once this cycle's pop and pending response settle.
  assign occ = {1'b0, buf_count} + {2'b0, in_flight} - {2'b0, pop};
  assign req = rst_n && !BranchTaken && (occ < 3'(BUF_DEPTH));

  assign buf_din = '{pc: in_flight_pc, instr: bus.ImemRdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      in_flight     <= 1'b0;
      in_flight_pc  <= '0;
      discard       <= 1'b0;
      MisalignFault <= 1'b0;
    end else if (BranchTaken) begin
      pc            <= {BranchPc[31:2], 2'b00};
      in_flight     <= 1'b0;
      discard       <= in_flight;
      MisalignFault <= |BranchPc[1:0];
    end else begin
      in_flight     <= req;
      discard       <= 1'b0;
      MisalignFault <= 1'b0;
      if (req) begin
        pc           <= pc + PC_STEP;
        in_flight_pc <= pc;
      end
    end
  end

  fetch_buffer u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (BranchTaken),
    .din   (buf_din),
    .head  (buf_head),
    .count (buf_count)
  );

  assign bus.ImemReq   = req;
  assign bus.ImemAddr  = pc;
  assign bus.IfIdValid = valid;
  assign bus.IfIdPc    = valid ? buf_head.pc : 32'h0;
  assign bus.IfIdInstr = valid ? buf_head.instr : INSTR_NOP;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stream, stall, redirect, wrap, reset.
// IMEM model returns addr + 0x100 one cycle after each request.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bt;
  logic [31:0] bpc;
  logic        mf;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.master),
    .BranchTaken   (bt),
    .BranchPc      (bpc),
    .MisalignFault (mf)
  );

  always @(posedge clk)
    if (bus.ImemReq) bus.ImemRdata <= bus.ImemAddr + 32'h100;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    chk("no_push_full",
        {31'b0, dut.push & (dut.buf_count == 2'd2)}, 32'd0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    bt = 1'b0;
    bpc = '0;
    bus.Stall = 1'b0;
    bus.ImemRdata = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", {31'b0, bus.IfIdValid}, 32'd0);
    chk("rst_instr", bus.IfIdInstr, 32'h13);
    chk("rst_pc", bus.IfIdPc, 32'h0);
    chk("rst_req", {31'b0, bus.ImemReq}, 32'd0);
    chk("rst_mf", {31'b0, mf}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("first_req", {31'b0, bus.ImemReq}, 32'd1);
    chk("first_addr", bus.ImemAddr, 32'h0);

    tick();
    chk("e1_valid", {31'b0, bus.IfIdValid}, 32'd0);
    chk("e1_addr", bus.ImemAddr, 32'h4);
    chk("e1_req", {31'b0, bus.ImemReq}, 32'd1);
    tick();
    chk("e2_valid", {31'b0, bus.IfIdValid}, 32'd1);
    chk("e2_pc", bus.IfIdPc, 32'h0);
    chk("e2_instr", bus.IfIdInstr, 32'h100);
    chk("e2_addr", bus.ImemAddr, 32'h8);
    tick();
    chk("e3_pc", bus.IfIdPc, 32'h4);
    chk("e3_instr", bus.IfIdInstr, 32'h104);
    tick();
    chk("e4_pc", bus.IfIdPc, 32'h8);

    bus.Stall = 1'b1;
    #1;
    chk("stall_req0", {31'b0, bus.ImemReq}, 32'd0);
    tick();
    chk("stall1_pc", bus.IfIdPc, 32'h8);
    chk("stall1_req", {31'b0, bus.ImemReq}, 32'd0);
    tick();
    tick();
    chk("stall3_pc", bus.IfIdPc, 32'h8);
    chk("stall3_req", {31'b0, bus.ImemReq}, 32'd0);
    chk("stall3_cnt", {30'b0, dut.buf_count}, 32'd2);
    tick();
    bus.Stall = 1'b0;
    #1;
    chk("rel_pc", bus.IfIdPc, 32'h8);
    chk("rel_req", {31'b0, bus.ImemReq}, 32'd1);
    chk("rel_addr", bus.ImemAddr, 32'h10);
    tick();
    chk("rel1_pc", bus.IfIdPc, 32'hC);
    chk("rel1_instr", bus.IfIdInstr, 32'h10C);
    tick();
    chk("rel2_pc", bus.IfIdPc, 32'h10);
    chk("rel2_instr", bus.IfIdInstr, 32'h110);

    bt = 1'b1;
    bpc = 32'h40;
    #1;
    chk("br_req0", {31'b0, bus.ImemReq}, 32'd0);
    tick();
    bt = 1'b0;
    #1;
    chk("br1_valid", {31'b0, bus.IfIdValid}, 32'd0);
    chk("br1_req", {31'b0, bus.ImemReq}, 32'd1);
    chk("br1_addr", bus.ImemAddr, 32'h40);
    chk("br1_mf", {31'b0, mf}, 32'd0);
    tick();
    chk("br2_valid", {31'b0, bus.IfIdValid}, 32'd0);
    chk("br2_addr", bus.ImemAddr, 32'h44);
    tick();
    chk("br3_valid", {31'b0, bus.IfIdValid}, 32'd1);
    chk("br3_pc", bus.IfIdPc, 32'h40);
    chk("br3_instr", bus.IfIdInstr, 32'h140);

    bt = 1'b1;
    bpc = 32'h42;
    tick();
    bt = 1'b0;
    #1;
    chk("mis_mf1", {31'b0, mf}, 32'd1);
    chk("mis_valid", {31'b0, bus.IfIdValid}, 32'd0);
    chk("mis_addr", bus.ImemAddr, 32'h40);
    tick();
    chk("mis_mf0", {31'b0, mf}, 32'd0);
    tick();
    chk("mis_pc", bus.IfIdPc, 32'h40);
    chk("mis_vld", {31'b0, bus.IfIdValid}, 32'd1);

    bus.Stall = 1'b1;
    bt = 1'b1;
    bpc = 32'h80;
    #1;
    chk("b2b_req0", {31'b0, bus.ImemReq}, 32'd0);
    tick();
    bpc = 32'hC0;
    #1;
    chk("b2b1_valid", {31'b0, bus.IfIdValid}, 32'd0);
    chk("b2b1_req", {31'b0, bus.ImemReq}, 32'd0);
    chk("b2b1_addr", bus.ImemAddr, 32'h80);
    tick();
    bt = 1'b0;
    bus.Stall = 1'b0;
    #1;
    chk("b2b2_valid", {31'b0, bus.IfIdValid}, 32'd0);
    chk("b2b2_addr", bus.ImemAddr, 32'hC0);
    chk("b2b2_req", {31'b0, bus.ImemReq}, 32'd1);
    tick();
    chk("b2b3_valid", {31'b0, bus.IfIdValid}, 32'd0);
    tick();
    chk("b2b4_valid", {31'b0, bus.IfIdValid}, 32'd1);
    chk("b2b4_pc", bus.IfIdPc, 32'hC0);
    chk("b2b4_instr", bus.IfIdInstr, 32'h1C0);

    bt = 1'b1;
    bpc = 32'hFFFF_FFF8;
    tick();
    bt = 1'b0;
    #1;
    chk("wrap_addr", bus.ImemAddr, 32'hFFFF_FFF8);
    tick();
    tick();
    chk("wrap1_pc", bus.IfIdPc, 32'hFFFF_FFF8);
    chk("wrap1_instr", bus.IfIdInstr, 32'h0000_00F8);
    chk("wrap1_addr", bus.ImemAddr, 32'h0);
    tick();
    chk("wrap2_pc", bus.IfIdPc, 32'hFFFF_FFFC);
    chk("wrap2_instr", bus.IfIdInstr, 32'h0000_00FC);
    tick();
    chk("wrap3_pc", bus.IfIdPc, 32'h0);
    chk("wrap3_instr", bus.IfIdInstr, 32'h100);

    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, bus.IfIdValid}, 32'd0);
    chk("arst_instr", bus.IfIdInstr, 32'h13);
    chk("arst_pc", bus.IfIdPc, 32'h0);
    chk("arst_req", {31'b0, bus.ImemReq}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst2_req", {31'b0, bus.ImemReq}, 32'd1);
    chk("rst2_addr", bus.ImemAddr, 32'h0);
    tick();
    tick();
    chk("rst2_valid", {31'b0, bus.IfIdValid}, 32'd1);
    chk("rst2_pc", bus.IfIdPc, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
